// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive path.
package uart_pkg;

    localparam int UART_CLOCK_RATE_HZ     = 16;
    localparam int UART_BAUD_RATE_HZ      = 1;
    localparam int UART_BITS_PER_TRANSFER = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

endpackage

// File: rtl/rx_shift_reg.sv
// Serial-in / parallel-out shift register, LSB first.
// The first bit shifted in ends up in q[0] after WIDTH shifts.
module rx_shift_reg
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_BITS_PER_TRANSFER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    // New bits enter at the MSB and move toward bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (shift) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing with mid-bit sampling off a falling start edge.
// Optional even parity bit is compiled in with `UART_RX_PARITY_EN.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rx_s
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling data bits at one-baud intervals
// PARITY | sampling the parity bit (parity builds only)
// STOP   | sampling the stop bit, delivering data or flagging a frame error
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE_HZ     = UART_CLOCK_RATE_HZ,
    parameter int BAUD_RATE_HZ      = UART_BAUD_RATE_HZ,
    parameter int BITS_PER_TRANSFER = UART_BITS_PER_TRANSFER,
    parameter int CLOCKS_PER_BAUD   = CLOCK_RATE_HZ / BAUD_RATE_HZ
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rx,
    output logic [BITS_PER_TRANSFER-1:0] data,
    output logic                         valid,
    output logic                         busy,
    output logic                         frame_err,
    output logic                         parity_err
);

    localparam logic [31:0] HALF_LAST = 32'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [31:0] BAUD_LAST = 32'(CLOCKS_PER_BAUD - 1);
    localparam logic [31:0] BITS_LAST = 32'(BITS_PER_TRANSFER - 1);

    logic rx_meta, rx_s, rx_d;
    uart_rx_state_t state, state_next;
    logic [31:0] baud_cnt, baud_cnt_next;
    logic [31:0] bit_cnt, bit_cnt_next;
    logic shift;
    logic data_load;
    logic valid_next, frame_err_next;
    logic [BITS_PER_TRANSFER-1:0] shift_q;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_load, parity_err_next;
`endif

    rx_shift_reg #(.WIDTH(BITS_PER_TRANSFER)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .shift (shift),
        .din   (rx_s),
        .q     (shift_q)
    );

    // Two-flop synchroniser plus a delayed copy for start-edge detection; idle high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state, counter and strobe decode.
    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt + 32'd1;
        bit_cnt_next   = bit_cnt;
        shift          = 1'b0;
        data_load      = 1'b0;
        valid_next     = 1'b0;
        frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_load        = 1'b0;
        parity_err_next = 1'b0;
`endif
        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                bit_cnt_next  = '0;
                if (rx_d && !rx_s) state_next = START;
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    shift         = 1'b1;
                    if (bit_cnt == BITS_LAST) begin
                        bit_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 32'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    par_load      = 1'b1;
                    state_next    = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_next = '0;
                    state_next    = IDLE;
                    if (rx_s) begin
                        data_load  = 1'b1;
                        valid_next = 1'b1;
`ifdef UART_RX_PARITY_EN
                        parity_err_next = ^{shift_q, par_bit};
`endif
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = '0;
            end
        endcase
    end

    // Counters, output register and strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            baud_cnt  <= baud_cnt_next;
            bit_cnt   <= bit_cnt_next;
            valid     <= valid_next;
            frame_err <= frame_err_next;
            if (data_load) data <= shift_q;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit capture and its error strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (par_load) par_bit <= rx_s;
            parity_err <= parity_err_next;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule
